mem_stage: RTL and testbench
============================

# mem_stage

Memory-access stage placed directly downstream of the execute stage. It registers the execute results (ALU result/address, forwarded store data, destination register, write-back enable) and performs RV32I loads and stores through a request/grant/response data-memory port. Loads are sign- or zero-extended, and store data is lane-steered with byte enables. While an access is outstanding it stalls the upstream pipeline, and it presents write-back data to the write-back stage.

## Interface
Parameters: none.

Ports:
- clk  in  1  pipeline clock, rising edge
- rst  in  1  asynchronous, active-high reset
- ex_valid  in  1  execute stage presents a valid instruction
- ex_result  in  32  ALU result; effective address for loads and stores
- ex_store_data  in  32  forwarded rs2 value (execute op2_selected)
- ex_opcode  in  7  instruction opcode
- ex_func3  in  3  instruction func3
- ex_rd  in  5  destination register
- ex_wb_reg_file  in  1  instruction writes the register file
- ex_ready  out  1  stage accepts the instruction this cycle
- mem_stall  out  1  access outstanding; upstream stages hold
- mem_fwd_data  out  32  captured ALU result, for the execute forwarding mux (select 01)
- dmem_req  out  1  memory request
- dmem_we  out  1  1 = store
- dmem_addr  out  32  word-aligned address ({addr[31:2],2'b00})
- dmem_wdata  out  32  lane-steered store data
- dmem_be  out  4  byte enables
- dmem_gnt  in  1  request accepted
- dmem_rvalid  in  1  load data valid
- dmem_rdata  in  32  load word
- wb_valid  out  1  write-back slot valid, one-cycle pulse per instruction
- wb_data  out  32  write-back value
- wb_rd  out  5  write-back destination
- wb_reg_file  out  1  register-file write enable (already qualified by wb_valid)
- misaligned  out  1  misaligned-access pulse (tied 0 when the feature is compiled out)

## Operation
- FSM states: IDLE, REQ, WAIT.
- ex_ready = (state == IDLE). mem_stall = !ex_ready.
- The stage captures an instruction on ex_valid & ex_ready. The captured fields are addr, sdata, opcode, func3, rd and wbrf.
- Non-memory opcodes stay in IDLE. The next cycle gives wb_valid=1, wb_data=addr, wb_rd=rd, wb_reg_file=wbrf.
- Load (0000011) or store (0100011): the FSM goes to REQ.
- In REQ, dmem_req=1 and the stage decodes from the captured fields:
  - dmem_we = store.
  - SB: be = 4'b0001 << addr[1:0]; wdata = byte replicated ×4.
  - SH: be = addr[1] ? 1100 : 0011; wdata = {h,h}.
  - SW: be = 1111.
  - Loads drive be = 1111.
- REQ & dmem_gnt:
  - Store: go to IDLE. Next cycle wb_valid=1 with wb_reg_file=0.
  - Load: go to WAIT.
- WAIT & dmem_rvalid: go to IDLE. Next cycle wb_valid=1, wb_data=extended lane, wb_reg_file=wbrf.
- Load extension selects the byte or halfword by addr[1:0] / addr[1]:
  - LB: sign-extend byte.
  - LH: sign-extend halfword.
  - LW: full word.
  - LBU/LHU: zero-extend.
  - Undefined func3: word.
- dmem_rvalid outside WAIT and dmem_gnt outside REQ are ignored.
- mem_fwd_data always equals the captured addr register.
- ex_valid=0 while in IDLE leaves a bubble: wb_valid=0 next cycle.

## Timing
- Reset values:
  - state=IDLE, so ex_ready=1, mem_stall=0, dmem_req=0.
  - wb_valid=0, wb_reg_file=0, wb_data=0, wb_rd=0, misaligned=0, mem_fwd_data=0.
- dmem_* outputs are combinational from state and captured registers; wb_* and misaligned are registered.
- Latency:
  - Non-memory: 1 cycle; sustains 1 instruction per cycle.
  - Store: 1 + k cycles, where k = REQ cycles up to and including the gnt cycle.
  - Load: 1 + k + m cycles, where m = WAIT cycles up to and including the rvalid cycle.
  - Zero-wait memory: store = 2 cycles, load = 3 cycles from capture to wb_valid.
- A new instruction is accepted in the same cycle the previous one completes, because the FSM is in IDLE on the following edge. It is not accepted in the gnt or rvalid cycle itself.
- The data memory must not assert rvalid in the gnt cycle; the earliest rvalid is the cycle after gnt.
- rst asserted mid-access forces IDLE immediately: dmem_req drops asynchronously and any pending response is discarded.

## Configuration
- MEM_MISALIGN_TRAP_EN defined:
  - Halfword with addr[0]=1, or word with addr[1:0]≠0, never enters REQ. No dmem_req is issued.
  - The next cycle gives misaligned=1 for one cycle and wb_valid=1 with wb_reg_file=0.
- Undefined: low address bits are ignored. Halfword uses addr[1] only; word uses lane 0. misaligned stays 0.

## Test plan
- Reset, then ADD with ex_result=0x1234, rd=5, wbrf=1 -> next cycle wb_valid=1, wb_data=0x1234, wb_rd=5, ex_ready stays 1.
- SB addr=0x103, data=0xAB, gnt on first REQ cycle -> dmem_be=1000, dmem_wdata=0xABABABAB, dmem_addr=0x100, dmem_we=1; wb_valid 2 cycles after capture with wb_reg_file=0.
- LH addr=0x202, gnt after 2 cycles, rvalid 3 cycles later with rdata=0x8001_0000 -> wb_data=0xFFFF8001; LHU variant -> wb_data=0x00008001; mem_stall high throughout REQ and WAIT.
- Back-to-back LW, then ADD held on ex_valid -> ADD accepted only after the LW rvalid cycle; wb pulses in order, no duplicates.
- rst asserted during WAIT, then rvalid -> dmem_req=0 at once, no wb_valid, ex_ready=1.
- With MEM_MISALIGN_TRAP_EN, LW addr=0x3 -> no dmem_req, misaligned=1 and wb_valid=1 with wb_reg_file=0 next cycle. Without the macro -> dmem_addr=0x0 read, wb_data=full word.

Source files
------------

// File: rtl/mem_stage.sv
// mem_stage: RV32I memory-access stage driving a req/gnt/rvalid data port.
// Define MEM_MISALIGN_TRAP_EN to trap misaligned halfword/word accesses.
module mem_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    input  logic [31:0] ex_result,
    input  logic [31:0] ex_store_data,
    input  logic [6:0]  ex_opcode,
    input  logic [2:0]  ex_func3,
    input  logic [4:0]  ex_rd,
    input  logic        ex_wb_reg_file,
    output logic        ex_ready,
    output logic        mem_stall,
    output logic [31:0] mem_fwd_data,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic        dmem_gnt,
    input  logic        dmem_rvalid,
    input  logic [31:0] dmem_rdata,
    output logic        wb_valid,
    output logic [31:0] wb_data,
    output logic [4:0]  wb_rd,
    output logic        wb_reg_file,
    output logic        misaligned
);

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

    state_t      state, state_nxt;
    logic [31:0] addr;
    logic [31:0] sdata;
    logic [6:0]  opcode;
    logic [2:0]  func3;
    logic [4:0]  rd;
    logic        wbrf;

    logic        accept;
    logic        ex_mem;
    logic        ex_mis;
    logic        is_store;
    logic [7:0]  lb;
    logic [15:0] lh;
    logic [31:0] ld_data;

    assign ex_ready     = (state == IDLE);
    assign mem_stall    = ~ex_ready;
    assign accept       = ex_valid & ex_ready;
    assign ex_mem       = (ex_opcode == OP_LOAD) | (ex_opcode == OP_STORE);
    assign is_store     = (opcode == OP_STORE);
    assign mem_fwd_data = addr;
    assign dmem_addr    = {addr[31:2], 2'b00};

`ifdef MEM_MISALIGN_TRAP_EN
    assign ex_mis = ex_mem &
                    (((ex_func3[1:0] == 2'b01) & ex_result[0]) |
                     ((ex_func3[1:0] == 2'b10) & (|ex_result[1:0])));
`else
    assign ex_mis = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        dmem_req   = 1'b0;
        dmem_we    = 1'b0;
        dmem_be    = 4'b0000;
        dmem_wdata = 32'h0;
        unique case (state)
            IDLE: begin
                if (accept & ex_mem & ~ex_mis) state_nxt = REQ;
            end
            REQ: begin
                dmem_req = 1'b1;
                dmem_we  = is_store;
                dmem_be  = 4'b1111;
                if (is_store) begin
                    unique case (1'b1)
                        func3 == 3'b000: begin
                            dmem_be    = 4'b0001 << addr[1:0];
                            dmem_wdata = {4{sdata[7:0]}};
                        end
                        func3 == 3'b001: begin
                            dmem_be    = addr[1] ? 4'b1100 : 4'b0011;
                            dmem_wdata = {2{sdata[15:0]}};
                        end
                        default: dmem_wdata = sdata;
                    endcase
                end
                if (dmem_gnt) state_nxt = is_store ? IDLE : WAIT;
            end
            WAIT: begin
                if (dmem_rvalid) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Lane selection for sub-word loads
    always_comb begin
        unique case (addr[1:0])
            2'b00: lb = dmem_rdata[7:0];
            2'b01: lb = dmem_rdata[15:8];
            2'b10: lb = dmem_rdata[23:16];
            2'b11: lb = dmem_rdata[31:24];
        endcase
        lh = addr[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        unique case (func3)
            3'b000:  ld_data = {{24{lb[7]}}, lb};
            3'b001:  ld_data = {{16{lh[15]}}, lh};
            3'b100:  ld_data = {24'h0, lb};
            3'b101:  ld_data = {16'h0, lh};
            default: ld_data = dmem_rdata;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr   <= 32'h0;
            sdata  <= 32'h0;
            opcode <= 7'h0;
            func3  <= 3'h0;
            rd     <= 5'h0;
            wbrf   <= 1'b0;
        end else if (accept) begin
            addr   <= ex_result;
            sdata  <= ex_store_data;
            opcode <= ex_opcode;
            func3  <= ex_func3;
            rd     <= ex_rd;
            wbrf   <= ex_wb_reg_file;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_valid    <= 1'b0;
            wb_data     <= 32'h0;
            wb_rd       <= 5'h0;
            wb_reg_file <= 1'b0;
            misaligned  <= 1'b0;
        end else begin
            wb_valid    <= 1'b0;
            wb_reg_file <= 1'b0;
            misaligned  <= 1'b0;
            if (accept & (~ex_mem | ex_mis)) begin
                wb_valid    <= 1'b1;
                wb_data     <= ex_result;
                wb_rd       <= ex_rd;
                wb_reg_file <= ex_wb_reg_file & ~ex_mem;
                misaligned  <= ex_mis;
            end else if ((state == REQ) & dmem_gnt & is_store) begin
                wb_valid <= 1'b1;
                wb_data  <= addr;
                wb_rd    <= rd;
            end else if ((state == WAIT) & dmem_rvalid) begin
                wb_valid    <= 1'b1;
                wb_data     <= ld_data;
                wb_rd       <= rd;
                wb_reg_file <= wbrf;
            end
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed and randomized checks of mem_stage
// against an arithmetic load/store reference model and memory responder.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid;
    logic [31:0] ex_result;
    logic [31:0] ex_store_data;
    logic [6:0]  ex_opcode;
    logic [2:0]  ex_func3;
    logic [4:0]  ex_rd;
    logic        ex_wb_reg_file;
    logic        ex_ready;
    logic        mem_stall;
    logic [31:0] mem_fwd_data;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_gnt;
    logic        dmem_rvalid;
    logic [31:0] dmem_rdata;
    logic        wb_valid;
    logic [31:0] wb_data;
    logic [4:0]  wb_rd;
    logic        wb_reg_file;
    logic        misaligned;

    mem_stage dut (
        .clk(clk), .rst(rst),
        .ex_valid(ex_valid), .ex_result(ex_result),
        .ex_store_data(ex_store_data), .ex_opcode(ex_opcode),
        .ex_func3(ex_func3), .ex_rd(ex_rd),
        .ex_wb_reg_file(ex_wb_reg_file), .ex_ready(ex_ready),
        .mem_stall(mem_stall), .mem_fwd_data(mem_fwd_data),
        .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_be(dmem_be), .dmem_gnt(dmem_gnt),
        .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
        .wb_valid(wb_valid), .wb_data(wb_data), .wb_rd(wb_rd),
        .wb_reg_file(wb_reg_file), .misaligned(misaligned)
    );

    always #5 clk = ~clk;

    localparam logic [6:0] OP_ALU = 7'b0110011;
    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] OP_LD  = 7'b0000011;
    localparam logic [6:0] OP_ST  = 7'b0100011;
`ifdef MEM_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Load value as seen by the register file
    function automatic logic [31:0] load_ref(input logic [2:0] f3,
            input logic [31:0] a, input logic [31:0] w);
        logic [31:0] bv, hv;
        bv = (w >> ((a % 4) * 8)) & 32'hFF;
        hv = (w >> (((a / 2) % 2) * 16)) & 32'hFFFF;
        case (f3)
            3'd0:    return (bv >= 32'd128) ? bv - 32'd256 : bv;
            3'd1:    return (hv >= 32'd32768) ? hv - 32'd65536 : hv;
            3'd4:    return bv;
            3'd5:    return hv;
            default: return w;
        endcase
    endfunction

    function automatic logic [3:0] be_ref(input logic [2:0] f3,
                                          input logic [31:0] a);
        case (f3)
            3'd0:    return 4'(32'd1 << (a % 4));
            3'd1:    return ((a % 4) >= 2) ? 4'hC : 4'h3;
            default: return 4'hF;
        endcase
    endfunction

    function automatic logic [31:0] wd_ref(input logic [2:0] f3,
                                           input logic [31:0] d);
        case (f3)
            3'd0:    return (d & 32'hFF) * 32'h01010101;
            3'd1:    return (d & 32'hFFFF) * 32'h00010001;
            default: return d;
        endcase
    endfunction

    // One instruction from IDLE to its write-back pulse; gd/vd = extra
    // REQ/WAIT cycles before gnt/rvalid. Enters and leaves just after negedge.
    task automatic do_instr(input logic [6:0] op, input logic [2:0] f3,
            input logic [31:0] a, input logic [31:0] sd,
            input logic [4:0] r, input logic wrf,
            input int gd, input int vd, input logic [31:0] w);
        bit is_ld, is_st, mis;
        is_ld = (op == OP_LD);
        is_st = (op == OP_ST);
        mis = TRAP && (is_ld || is_st) &&
              ((((f3 % 4) == 1) && ((a % 2) != 0)) ||
               (((f3 % 4) == 2) && ((a % 4) != 0)));
        chk("ex_ready_idle", 32'(ex_ready), 32'd1);
        ex_valid       = 1'b1;
        ex_opcode      = op;
        ex_func3       = f3;
        ex_result      = a;
        ex_store_data  = sd;
        ex_rd          = r;
        ex_wb_reg_file = wrf;
        dmem_gnt       = 1'($urandom_range(0, 1));
        dmem_rvalid    = 1'($urandom_range(0, 1));
        dmem_rdata     = $urandom;
        @(negedge clk);
        ex_valid    = 1'b0;
        dmem_gnt    = 1'b0;
        dmem_rvalid = 1'b0;
        chk("fwd_data", mem_fwd_data, a);
        if (!(is_ld || is_st) || mis) begin
            chk("wb_valid_alu", 32'(wb_valid), 32'd1);
            chk("wb_data_alu", wb_data, a);
            chk("wb_rd_alu", 32'(wb_rd), 32'(r));
            chk("wb_rf_alu", 32'(wb_reg_file), 32'((is_ld || is_st) ? 1'b0 : wrf));
            chk("misaligned", 32'(misaligned), 32'(mis));
            chk("no_req", 32'(dmem_req), 32'd0);
            return;
        end
        for (int i = 0; i <= gd; i++) begin
            chk("req", 32'(dmem_req), 32'd1);
            chk("stall_req", 32'(mem_stall), 32'd1);
            chk("we", 32'(dmem_we), 32'(is_st));
            chk("addr", dmem_addr, a & 32'hFFFF_FFFC);
            chk("be", 32'(dmem_be), 32'(is_st ? be_ref(f3, a) : 4'hF));
            if (is_st) chk("wdata", dmem_wdata, wd_ref(f3, sd));
            chk("wb_quiet_req", 32'(wb_valid), 32'd0);
            dmem_gnt    = (i == gd);
            dmem_rvalid = (i != gd) ? 1'($urandom_range(0, 1)) : 1'b0;
            @(negedge clk);
        end
        dmem_gnt    = 1'b0;
        dmem_rvalid = 1'b0;
        if (is_st) begin
            chk("wb_valid_st", 32'(wb_valid), 32'd1);
            chk("wb_rf_st", 32'(wb_reg_file), 32'd0);
            chk("mis_st", 32'(misaligned), 32'd0);
            chk("ready_st", 32'(ex_ready), 32'd1);
            return;
        end
        for (int j = 0; j <= vd; j++) begin
            chk("no_req_wait", 32'(dmem_req), 32'd0);
            chk("stall_wait", 32'(mem_stall), 32'd1);
            chk("wb_quiet_wait", 32'(wb_valid), 32'd0);
            dmem_rvalid = (j == vd);
            dmem_rdata  = (j == vd) ? w : $urandom;
            dmem_gnt    = (j != vd) ? 1'($urandom_range(0, 1)) : 1'b0;
            @(negedge clk);
        end
        dmem_rvalid = 1'b0;
        dmem_gnt    = 1'b0;
        chk("wb_valid_ld", 32'(wb_valid), 32'd1);
        chk("wb_data_ld", wb_data, load_ref(f3, a, w));
        chk("wb_rd_ld", 32'(wb_rd), 32'(r));
        chk("wb_rf_ld", 32'(wb_reg_file), 32'(wrf));
        chk("mis_ld", 32'(misaligned), 32'd0);
        chk("ready_ld", 32'(ex_ready), 32'd1);
    endtask

    logic [2:0]  ld_f3 [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    logic [6:0]  op;
    logic [2:0]  f3;
    int          sel;

    initial begin
        rst = 1'b1;
        ex_valid = 1'b0;
        ex_result = '0;
        ex_store_data = '0;
        ex_opcode = '0;
        ex_func3 = '0;
        ex_rd = '0;
        ex_wb_reg_file = 1'b0;
        dmem_gnt = 1'b0;
        dmem_rvalid = 1'b0;
        dmem_rdata = '0;
        repeat (2) @(negedge clk);
        chk("rst_ready", 32'(ex_ready), 32'd1);
        chk("rst_stall", 32'(mem_stall), 32'd0);
        chk("rst_req", 32'(dmem_req), 32'd0);
        chk("rst_wb_valid", 32'(wb_valid), 32'd0);
        chk("rst_wb_rf", 32'(wb_reg_file), 32'd0);
        chk("rst_wb_data", wb_data, 32'd0);
        chk("rst_wb_rd", 32'(wb_rd), 32'd0);
        chk("rst_mis", 32'(misaligned), 32'd0);
        chk("rst_fwd", mem_fwd_data, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Directed cases
        do_instr(OP_ALU, 3'd0, 32'h1234, 32'h0, 5'd5, 1'b1, 0, 0, 32'h0);
        do_instr(OP_ST, 3'd0, 32'h103, 32'hAB, 5'd1, 1'b0, 0, 0, 32'h0);
        do_instr(OP_LD, 3'd1, 32'h202, 32'h0, 5'd7, 1'b1, 2, 2, 32'h8001_0000);
        do_instr(OP_LD, 3'd5, 32'h202, 32'h0, 5'd8, 1'b1, 2, 2, 32'h8001_0000);
        do_instr(OP_LD, 3'd2, 32'h3, 32'h0, 5'd9, 1'b1, 0, 0, 32'hDEAD_BEEF);
        @(negedge clk);
        chk("bubble", 32'(wb_valid), 32'd0);

        // LW followed by an ADD held on ex_valid
        ex_valid = 1'b1; ex_opcode = OP_LD; ex_func3 = 3'd2;
        ex_result = 32'h40; ex_rd = 5'd3; ex_wb_reg_file = 1'b1;
        @(negedge clk);
        ex_opcode = OP_ALU; ex_func3 = 3'd0; ex_result = 32'h5555;
        ex_rd = 5'd4;
        chk("hold_req_ready", 32'(ex_ready), 32'd0);
        dmem_gnt = 1'b1;
        @(negedge clk);
        dmem_gnt = 1'b0;
        chk("hold_wait_ready", 32'(ex_ready), 32'd0);
        chk("hold_wait_wb", 32'(wb_valid), 32'd0);
        @(negedge clk);
        chk("hold_wait2_wb", 32'(wb_valid), 32'd0);
        dmem_rvalid = 1'b1; dmem_rdata = 32'h0BAD_F00D;
        @(negedge clk);
        dmem_rvalid = 1'b0;
        chk("hold_lw_wb", 32'(wb_valid), 32'd1);
        chk("hold_lw_data", wb_data, 32'h0BAD_F00D);
        chk("hold_lw_rd", 32'(wb_rd), 32'd3);
        chk("hold_ready", 32'(ex_ready), 32'd1);
        @(negedge clk);
        ex_valid = 1'b0;
        chk("hold_add_wb", 32'(wb_valid), 32'd1);
        chk("hold_add_data", wb_data, 32'h5555);
        chk("hold_add_rd", 32'(wb_rd), 32'd4);
        @(negedge clk);
        chk("hold_no_dup", 32'(wb_valid), 32'd0);

        // Reset during REQ, then during WAIT
        ex_valid = 1'b1; ex_opcode = OP_LD; ex_result = 32'h80;
        @(negedge clk);
        ex_valid = 1'b0;
        chk("rreq_req", 32'(dmem_req), 32'd1);
        rst = 1'b1;
        #1;
        chk("rreq_drop", 32'(dmem_req), 32'd0);
        chk("rreq_ready", 32'(ex_ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        ex_valid = 1'b1;
        @(negedge clk);
        ex_valid = 1'b0; dmem_gnt = 1'b1;
        @(negedge clk);
        dmem_gnt = 1'b0;
        chk("rwait_stall", 32'(mem_stall), 32'd1);
        rst = 1'b1;
        #1;
        chk("rwait_ready", 32'(ex_ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        dmem_rvalid = 1'b1;
        @(negedge clk);
        dmem_rvalid = 1'b0;
        chk("rwait_no_wb", 32'(wb_valid), 32'd0);
        chk("rwait_idle", 32'(ex_ready), 32'd1);

        // Randomized instruction stream
        for (int k = 0; k < 150; k++) begin
            sel = $urandom_range(0, 3);
            case (sel)
                0:       begin op = OP_ALU; f3 = 3'($urandom); end
                1:       begin op = OP_IMM; f3 = 3'($urandom); end
                2:       begin op = OP_LD; f3 = ld_f3[$urandom_range(0, 4)]; end
                default: begin op = OP_ST; f3 = 3'($urandom_range(0, 2)); end
            endcase
            do_instr(op, f3, $urandom, $urandom, 5'($urandom),
                     1'($urandom), $urandom_range(0, 2),
                     $urandom_range(0, 2), $urandom);
            if ($urandom_range(0, 3) == 0) begin
                @(negedge clk);
                chk("rand_bubble", 32'(wb_valid), 32'd0);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
